// File: rtl/sdpram_pkg.sv
// Shared helpers for the SDPRAM FIFO controller: read latency and pointer width.
package sdpram_pkg;

  function automatic int read_lat(input bit out_reg);
    return out_reg ? 2 : 1;
  endfunction

  // One extra MSB on each pointer tells a full FIFO apart from an empty one.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter (ADDR_WIDTH+1 bits) with increment and synchronous clear.
// Exposes the next value so the owner can register flags in step with the pointer.
module fifo_ptr
  import sdpram_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [ptr_width(AW)-1:0] ptr_o,
  output logic [ptr_width(AW)-1:0] ptr_nx_o
);

  localparam int PW = ptr_width(AW);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o    = ptr_q;
  assign ptr_nx_o = ptr_d;

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// FIFO controller sequencing a single-clock simple-dual-port RAM: address/strobe generation,
// registered occupancy flags, sticky over/underflow and a read-valid pipe matched to RAM latency.
module sdpram_fifo_ctrl
  import sdpram_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "FALSE",
  parameter int    AFULL_TH   = 2**ADDR_WIDTH - 4,
  parameter int    AEMPTY_TH  = 4
) (
  input  logic                  CLK_I,
  input  logic                  RSTN_I,
  input  logic                  CLR_I,
  input  logic                  WR_I,
  input  logic [DATA_WIDTH-1:0] WDATA_I,
  input  logic                  RD_I,
  output logic [DATA_WIDTH-1:0] RDATA_O,
  output logic                  RVALID_O,
  output logic                  FULL_O,
  output logic                  EMPTY_O,
  output logic                  ALMOST_FULL_O,
  output logic                  ALMOST_EMPTY_O,
  output logic [ADDR_WIDTH:0]   COUNT_O,
  output logic                  OVF_O,
  output logic                  UDF_O,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR_O,
  output logic                  RAM_WE_O,
  output logic [DATA_WIDTH-1:0] RAM_WDATA_O,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR_O,
  output logic                  RAM_RE_O,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA_I
);

  localparam int            PW       = ptr_width(ADDR_WIDTH);
  localparam int            LAT      = read_lat(OUTPUT_REG == "TRUE");
  localparam logic [PW-1:0] DEPTH_C  = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [PW-1:0]  wptr, wptr_nx, rptr, rptr_nx, count_nx;
  logic           wr_ok, rd_ok;
  logic           full_q, full_d, empty_q, empty_d;
  logic           afull_q, afull_d, aempty_q, aempty_d;
  logic           ovf_q, ovf_d, udf_q, udf_d;
  logic [LAT-1:0] vld_q, vld_d;

  // Full and empty both block outright, so a read and write never hit the same address.
  assign wr_ok = WR_I & ~full_q & ~CLR_I;
  assign rd_ok = RD_I & ~empty_q & ~CLR_I;

  fifo_ptr #(.AW(ADDR_WIDTH)) u_wptr (
    .clk_i    (CLK_I),
    .rst_ni   (RSTN_I),
    .clr_i    (CLR_I),
    .inc_i    (wr_ok),
    .ptr_o    (wptr),
    .ptr_nx_o (wptr_nx)
  );

  fifo_ptr #(.AW(ADDR_WIDTH)) u_rptr (
    .clk_i    (CLK_I),
    .rst_ni   (RSTN_I),
    .clr_i    (CLR_I),
    .inc_i    (rd_ok),
    .ptr_o    (rptr),
    .ptr_nx_o (rptr_nx)
  );

  always_comb begin
    count_nx = wptr_nx - rptr_nx;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    vld_d    = '0;
    if (CLR_I) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d    = ovf_q | (WR_I & full_q);
      udf_d    = udf_q | (RD_I & empty_q);
      vld_d[0] = rd_ok;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
    // Flags come from next-state pointers so they line up with COUNT_O after the edge.
    full_d   = (count_nx == DEPTH_C);
    empty_d  = (count_nx == '0);
    afull_d  = (count_nx >= AFULL_C);
    aempty_d = (count_nx <= AEMPTY_C);
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_q    <= '0;
    end else begin
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= vld_d;
    end
  end

  assign COUNT_O        = wptr - rptr;
  assign FULL_O         = full_q;
  assign EMPTY_O        = empty_q;
  assign ALMOST_FULL_O  = afull_q;
  assign ALMOST_EMPTY_O = aempty_q;
  assign OVF_O          = ovf_q;
  assign UDF_O          = udf_q;
  assign RVALID_O       = vld_q[LAT-1];
  assign RDATA_O        = RAM_RDATA_I;

  assign RAM_WADDR_O = wptr[ADDR_WIDTH-1:0];
  assign RAM_RADDR_O = rptr[ADDR_WIDTH-1:0];
  assign RAM_WE_O    = wr_ok;
  assign RAM_RE_O    = rd_ok;
  assign RAM_WDATA_O = WDATA_I;

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Bench for sdpram_fifo_ctrl: two instances (RAM latency 1 and 2) driven in lockstep,
// each wired to a behavioural single-clock SDPRAM, checked against a queue model.
module tb_sdpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rstn, clr, wr, rd;
  logic [7:0] wdata;

  always #5 clk = ~clk;

  logic [7:0] rdata_f, rdata_t, ram_wd_f, ram_wd_t, ram_rd_f, ram_rd_t;
  logic       rv_f, rv_t, full_f, full_t, emp_f, emp_t, af_f, af_t, ae_f, ae_t;
  logic       ovf_f, ovf_t, udf_f, udf_t, we_f, we_t, re_f, re_t;
  logic [4:0] cnt_f, cnt_t;
  logic [3:0] wa_f, wa_t, ra_f, ra_t;

  sdpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("FALSE")) u_dut_f (
    .CLK_I(clk), .RSTN_I(rstn), .CLR_I(clr), .WR_I(wr), .WDATA_I(wdata), .RD_I(rd),
    .RDATA_O(rdata_f), .RVALID_O(rv_f), .FULL_O(full_f), .EMPTY_O(emp_f),
    .ALMOST_FULL_O(af_f), .ALMOST_EMPTY_O(ae_f), .COUNT_O(cnt_f), .OVF_O(ovf_f), .UDF_O(udf_f),
    .RAM_WADDR_O(wa_f), .RAM_WE_O(we_f), .RAM_WDATA_O(ram_wd_f), .RAM_RADDR_O(ra_f),
    .RAM_RE_O(re_f), .RAM_RDATA_I(ram_rd_f)
  );

  sdpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("TRUE")) u_dut_t (
    .CLK_I(clk), .RSTN_I(rstn), .CLR_I(clr), .WR_I(wr), .WDATA_I(wdata), .RD_I(rd),
    .RDATA_O(rdata_t), .RVALID_O(rv_t), .FULL_O(full_t), .EMPTY_O(emp_t),
    .ALMOST_FULL_O(af_t), .ALMOST_EMPTY_O(ae_t), .COUNT_O(cnt_t), .OVF_O(ovf_t), .UDF_O(udf_t),
    .RAM_WADDR_O(wa_t), .RAM_WE_O(we_t), .RAM_WDATA_O(ram_wd_t), .RAM_RADDR_O(ra_t),
    .RAM_RE_O(re_t), .RAM_RDATA_I(ram_rd_t)
  );

  // Behavioural RAMs: registered read, plus an output register for the latency-2 copy.
  logic [7:0] mem_f [16];
  logic [7:0] mem_t [16];
  logic [7:0] rq_t;
  always @(posedge clk) begin
    if (we_f) mem_f[wa_f] <= ram_wd_f;
    if (re_f) ram_rd_f <= mem_f[ra_f];
    if (we_t) mem_t[wa_t] <= ram_wd_t;
    if (re_t) rq_t <= mem_t[ra_t];
    ram_rd_t <= rq_t;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0] mq[$];
  logic [7:0] got_f[$];
  logic [7:0] got_t[$];
  int         m_w, m_r;
  bit         m_ovf, m_udf, f_v, t_v1, t_v2;
  logic [7:0] f_d, t_d1, t_d2;

  task automatic model_reset();
    mq.delete();
    m_w = 0; m_r = 0; m_ovf = 0; m_udf = 0;
    f_v = 0; t_v1 = 0; t_v2 = 0;
  endtask

  task automatic chk_dut(input string n, input logic [4:0] cnt, input logic emp, input logic full,
                         input logic af, input logic ae, input logic ov, input logic ud,
                         input logic rv, input logic [7:0] rdat, input bit ev, input logic [7:0] ed);
    int sz;
    sz = mq.size();
    chk({n, "_count"}, cnt, sz);
    chk({n, "_empty"}, emp, sz == 0);
    chk({n, "_full"}, full, sz == 16);
    chk({n, "_afull"}, af, sz >= 12);
    chk({n, "_aempty"}, ae, sz <= 4);
    chk({n, "_ovf"}, ov, m_ovf);
    chk({n, "_udf"}, ud, m_udf);
    chk({n, "_rvalid"}, rv, ev);
    if (ev) chk({n, "_rdata"}, rdat, ed);
  endtask

  task automatic cyc(input bit wr_i, input logic [7:0] wd_i, input bit rd_i, input bit clr_i);
    bit         wok, rok, was_full, was_empty;
    logic [7:0] d;
    wr = wr_i; wdata = wd_i; rd = rd_i; clr = clr_i;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    wok = wr_i && !was_full && !clr_i;
    rok = rd_i && !was_empty && !clr_i;
    d   = 8'h00;
    #1;
    chk("we_f", we_f, wok);
    chk("we_t", we_t, wok);
    chk("re_f", re_f, rok);
    chk("re_t", re_t, rok);
    if (wok) begin
      chk("waddr_f", wa_f, m_w);
      chk("waddr_t", wa_t, m_w);
      chk("wdata_f", ram_wd_f, wd_i);
    end
    if (rok) begin
      chk("raddr_f", ra_f, m_r);
      chk("raddr_t", ra_t, m_r);
    end
    @(posedge clk);
    if (clr_i) begin
      model_reset();
    end else begin
      if (rok) begin
        d   = mq.pop_front();
        m_r = (m_r + 1) % 16;
      end
      if (wok) begin
        mq.push_back(wd_i);
        m_w = (m_w + 1) % 16;
      end
      m_ovf = m_ovf | (wr_i && was_full);
      m_udf = m_udf | (rd_i && was_empty);
      t_v2 = t_v1; t_d2 = t_d1;
      t_v1 = rok;  t_d1 = d;
      f_v  = rok;  f_d  = d;
    end
    @(negedge clk);
    chk_dut("f", cnt_f, emp_f, full_f, af_f, ae_f, ovf_f, udf_f, rv_f, rdata_f, f_v, f_d);
    chk_dut("t", cnt_t, emp_t, full_t, af_t, ae_t, ovf_t, udf_t, rv_t, rdata_t, t_v2, t_d2);
    if (rv_f) got_f.push_back(rdata_f);
    if (rv_t) got_t.push_back(rdata_t);
  endtask

  initial begin
    rstn = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; wdata = 8'h00;
    model_reset();
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", cnt_f, 0);
    chk("rst_empty", emp_f, 1);
    chk("rst_aempty", ae_t, 1);
    chk("rst_full", full_t, 0);
    rstn = 1'b1;
    cyc(0, 8'h00, 0, 0);

    // Fill with 70,72,..,100, then one push too many
    for (int i = 0; i < 16; i++) cyc(1, 8'(70 + 2 * i), 0, 0);
    chk("fill_full", full_f, 1);
    chk("fill_count", cnt_t, 16);
    cyc(1, 8'd102, 0, 0);
    chk("fill_ovf", ovf_f, 1);
    chk("fill_count_after_extra", cnt_f, 16);

    // Drain both latencies, then pop an empty FIFO
    got_f.delete();
    got_t.delete();
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    repeat (2) cyc(0, 8'h00, 0, 0);
    chk("drain_n_f", got_f.size(), 16);
    chk("drain_n_t", got_t.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_f.size()) chk("drain_data_f", got_f[i], 70 + 2 * i);
      if (i < got_t.size()) chk("drain_data_t", got_t[i], 70 + 2 * i);
    end
    chk("drain_empty", emp_t, 1);
    cyc(0, 8'h00, 1, 0);
    chk("udf_set", udf_f, 1);
    repeat (2) cyc(0, 8'h00, 0, 0);

    // Steady state at occupancy 8 with simultaneous push/pop across the wrap
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 8'(i + 1), 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 8'(i + 9), 1, 0);
    chk("steady_count", cnt_f, 8);
    chk("steady_count_t", cnt_t, 8);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
    repeat (2) cyc(0, 8'h00, 0, 0);

    // Push and pop together on an empty FIFO: no fall-through
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h55, 1, 0);
    chk("ft_count", cnt_f, 1);
    chk("ft_udf", udf_t, 1);
    chk("ft_rvalid", rv_f, 0);

    // Reach occupancy 5 with both sticky flags set, then clear with a push pending
    for (int i = 0; i < 15; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 8'h00, 1, 0);
    chk("pre_clr_count", cnt_f, 5);
    chk("pre_clr_ovf", ovf_f, 1);
    cyc(1, 8'h99, 0, 1);
    chk("clr_count", cnt_f, 0);
    chk("clr_empty", emp_t, 1);
    chk("clr_ovf", ovf_t, 0);
    chk("clr_udf", udf_f, 0);

    // Asynchronous reset in the middle of a push burst
    for (int i = 0; i < 6; i++) cyc(1, 8'(8'h40 + i), i > 2, 0);
    wr = 1'b1; rd = 1'b1; wdata = 8'h77;
    #2 rstn = 1'b0;
    #1;
    chk("arst_count_f", cnt_f, 0);
    chk("arst_count_t", cnt_t, 0);
    chk("arst_empty", emp_f, 1);
    chk("arst_aempty", ae_t, 1);
    chk("arst_rvalid_f", rv_f, 0);
    chk("arst_rvalid_t", rv_t, 0);
    wr = 1'b0; rd = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    cyc(0, 8'h00, 0, 0);
    chk("post_rst_count", cnt_t, 0);
    cyc(1, 8'h11, 0, 0);
    cyc(0, 8'h00, 1, 0);
    repeat (2) cyc(0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
